// File: rtl/pseudo_spi_rx_pkg.sv
// rtl/pseudo_spi_rx_pkg.sv - shared parameters and state encoding for the pseudo-SPI receiver
package pseudo_spi_rx_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 9;
    localparam int LEN_W_DEF    = 8;
    localparam int SLOT_CYC_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } rx_state_t;

endpackage

// File: rtl/pseudo_spi_rx_if.sv
// rtl/pseudo_spi_rx_if.sv - SRAM write port driven by the pseudo-SPI receiver
interface pseudo_spi_rx_if
    import pseudo_spi_rx_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] PO;
    logic              CEN;
    logic              D_WE;

    modport master (output A, output PO, output CEN, output D_WE);
    modport slave  (input  A, input  PO, input  CEN, input  D_WE);

endinterface

// File: rtl/pseudo_spi_rx_phase_gen.sv
// rtl/pseudo_spi_rx_phase_gen.sv - slot phase counter with SCLK1/SCLK2 decode
module pseudo_spi_rx_phase_gen
    import pseudo_spi_rx_pkg::*;
#(
    parameter int SLOT_CYC = SLOT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic slot_end,
    output logic sclk1,
    output logic sclk2
);

    localparam int PH_W = $clog2(SLOT_CYC);

    logic [PH_W-1:0] ph;

    // Counter parks at the top of the slot while disabled so each slot starts aligned.
    always_ff @(posedge clk) begin
        if (rst || !en || ph == '0) begin
            ph <= PH_W'(SLOT_CYC - 1);
        end else begin
            ph <= ph - PH_W'(1);
        end
    end

    assign slot_end = en && (ph == '0);
    assign sclk1    = en && (ph == PH_W'(3));
    assign sclk2    = en && (ph == PH_W'(1));

endmodule

// File: rtl/pseudo_spi_rx.sv
// rtl/pseudo_spi_rx.sv - pseudo-SPI receiver: shift clocks, LSB-first capture, SRAM word writes
module pseudo_spi_rx
    import pseudo_spi_rx_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LEN_W    = LEN_W_DEF,
    parameter int SLOT_CYC = SLOT_CYC_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BGN,
    input  logic [ADDR_W-1:0] ADDR_BGN,
    input  logic [LEN_W-1:0]  DATA_LEN,
    input  logic              SPI_SI,
    output logic              SCLK1,
    output logic              SCLK2,
    output logic              SEL,
    pseudo_spi_rx_if.master   sram,
    output logic              spi_busy,
    output logic              spi_is_done
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    rx_state_t         state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;

    logic abort, phase_en, slot_end, ph_sclk1, ph_sclk2;
    logic sclk1_nx, sclk2_nx, sel_nx, cen_nx, we_nx, busy_nx, done_nx;

    assign abort    = (state != ST_IDLE) && !BGN;
    assign phase_en = !abort && (state == ST_SETUP || state == ST_SHIFT);

    pseudo_spi_rx_phase_gen #(
        .SLOT_CYC (SLOT_CYC)
    ) u_phase (
        .clk      (CLK),
        .rst      (RST),
        .en       (phase_en),
        .slot_end (slot_end),
        .sclk1    (ph_sclk1),
        .sclk2    (ph_sclk2)
    );

    // Outputs are decoded from the current state and registered, so pins lag the state by one cycle.
    always_comb begin
        state_nx = state;
        sclk1_nx = 1'b0;
        sclk2_nx = 1'b0;
        sel_nx   = 1'b0;
        cen_nx   = 1'b1;
        we_nx    = 1'b1;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (BGN) begin
                        state_nx = (DATA_LEN == '0) ? ST_DONE : ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    sel_nx  = 1'b1;
                    busy_nx = 1'b1;
                    if (slot_end) begin
                        state_nx = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sel_nx   = 1'b1;
                    busy_nx  = 1'b1;
                    sclk1_nx = ph_sclk1;
                    sclk2_nx = ph_sclk2;
                    if (slot_end && bit_cnt == LAST_BIT) begin
                        state_nx = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    sel_nx   = 1'b1;
                    busy_nx  = 1'b1;
                    cen_nx   = 1'b0;
                    we_nx    = 1'b0;
                    state_nx = (cnt_q == LEN_W'(1)) ? ST_DONE : ST_SHIFT;
                end
                ST_DONE: begin
                    done_nx = 1'b1;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            SCLK1       <= 1'b0;
            SCLK2       <= 1'b0;
            SEL         <= 1'b0;
            sram.A      <= '0;
            sram.PO     <= '0;
            sram.CEN    <= 1'b1;
            sram.D_WE   <= 1'b1;
            spi_busy    <= 1'b0;
            spi_is_done <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
        end else begin
            state       <= state_nx;
            SCLK1       <= sclk1_nx;
            SCLK2       <= sclk2_nx;
            SEL         <= sel_nx;
            sram.CEN    <= cen_nx;
            sram.D_WE   <= we_nx;
            spi_busy    <= busy_nx;
            spi_is_done <= done_nx;
            case (state)
                ST_IDLE: begin
                    if (BGN) begin
                        addr_q  <= ADDR_BGN;
                        cnt_q   <= DATA_LEN;
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (slot_end) begin
                        shreg   <= {SPI_SI, shreg[DATA_W-1:1]};
                        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (!abort) begin
                        sram.A  <= addr_q;
                        sram.PO <= shreg;
                        addr_q  <= addr_q + ADDR_W'(1);
                        cnt_q   <= cnt_q - LEN_W'(1);
                        shreg   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
